// File: rtl/uart_tx_ctrl.sv
// rtl/uart_tx_ctrl.sv - UART transmit framer driving a shift_reg serializer
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_tx_ctrl #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       start,
  input  logic [7:0] Data_in,
  input  logic       tx_data,
  output logic       load,
  output logic       shift,
  output logic [7:0] Data,
  output logic       tx,
  output logic       busy,
  output logic       done
);
  localparam int            BW        = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
`ifdef UART_TX_PARITY_EN
    , S_PARITY
`endif
  } state_t;

  state_t        state_q;
  logic [BW-1:0] baud_q;
  logic [2:0]    bit_q;
  logic [7:0]    data_q;
  logic          bit_end;

  assign bit_end = (baud_q == BAUD_LAST);

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      data_q  <= '0;
    end else begin
      if (state_q != S_IDLE) begin
        baud_q <= bit_end ? '0 : baud_q + BW'(1);
      end
      case (state_q)
        S_IDLE: begin
          if (start) begin
            data_q  <= Data_in;
            baud_q  <= '0;
            bit_q   <= '0;
            state_q <= S_START;
          end
        end
        S_START: begin
          if (bit_end) begin
            bit_q   <= '0;
            state_q <= S_DATA;
          end
        end
        S_DATA: begin
          if (bit_end) begin
            bit_q <= bit_q + 3'd1;
            if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state_q <= S_PARITY;
`else
              state_q <= S_STOP;
`endif
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (bit_end) state_q <= S_STOP;
        end
`endif
        S_STOP: begin
          if (bit_end) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Load on the first START cycle so shift_reg holds bit 0 before DATA begins.
  always_comb begin
    tx    = 1'b1;
    load  = 1'b0;
    shift = 1'b0;
    done  = 1'b0;
    case (state_q)
      S_START: begin
        tx   = 1'b0;
        load = (baud_q == '0);
      end
      S_DATA: begin
        tx    = tx_data;
        shift = bit_end;
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: tx = ^data_q;
`endif
      S_STOP:  done = bit_end;
      default: ;
    endcase
  end

  assign busy = (state_q != S_IDLE);
  assign Data = data_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb/tb_uart_tx_ctrl.sv - self-checking bench for uart_tx_ctrl with a modelled shift_reg
module tb_uart_tx_ctrl;
  localparam int N = 4;
`ifdef UART_TX_PARITY_EN
  localparam int FL = 11 * N;
`else
  localparam int FL = 10 * N;
`endif

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic       start = 1'b0;
  logic [7:0] Data_in = 8'h00;
  logic       tx_data;
  logic       load, shift, tx, busy, done;
  logic [7:0] Data;
  logic [7:0] sr_q = 8'h00;

  int checks = 0;
  int failures = 0;

  uart_tx_ctrl #(.CLKS_PER_BIT(N)) dut (
    .clk    (clk),
    .clr    (clr),
    .start  (start),
    .Data_in(Data_in),
    .tx_data(tx_data),
    .load   (load),
    .shift  (shift),
    .Data   (Data),
    .tx     (tx),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  // shift_reg stand-in with its 1 ns update delay
  always @(posedge clk) begin : sr_upd
    logic       l, s;
    logic [7:0] d;
    l = load;
    s = shift;
    d = Data;
    #1;
    if (l) sr_q = d;
    else if (s) sr_q = {1'b0, sr_q[7:1]};
  end
  assign tx_data = sr_q[0];

  typedef struct {
    logic [7:0] data;
    string      bits;
  } vec_t;
  vec_t vecs[5];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_s(input string name, input string act, input string exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %s expected %s", name, act, exp);
    end
  endtask

  function automatic string model_bits(input logic [7:0] b);
    string s;
    s = "0";
    for (int i = 0; i < 8; i++) s = {s, b[i] ? "1" : "0"};
`ifdef UART_TX_PARITY_EN
    s = {s, (^b) ? "1" : "0"};
`endif
    s = {s, "1"};
    return s;
  endfunction

  // Caller is at a negedge with the DUT idle; optionally pokes start/0xFF mid-DATA.
  task automatic send_and_check(input logic [7:0] b, input string exp, input string tag,
                                input bit poke);
    int    loads, shifts, done_at, busy_n;
    string got;
    loads = 0; shifts = 0; done_at = -1; busy_n = 0; got = "";
    @(negedge clk);
    start = 1'b1;
    Data_in = b;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= FL; c++) begin
      loads  += int'(load);
      shifts += int'(shift);
      busy_n += int'(busy);
      if (done) done_at = c;
      if ((c - 1) % N == N / 2) got = {got, tx ? "1" : "0"};
      if (poke && c == 2 * N + 1) begin
        start = 1'b1;
        Data_in = 8'hFF;
      end else if (poke && c == 2 * N + 2) begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    chk_s({tag, " tx bits"}, got, exp);
    chk({tag, " load count"}, loads, 1);
    chk({tag, " shift count"}, shifts, 8);
    chk({tag, " done cycle"}, done_at, FL);
    chk({tag, " busy cycles"}, busy_n, FL);
    chk({tag, " idle busy"}, int'(busy), 0);
    chk({tag, " idle tx"}, int'(tx), 1);
    chk({tag, " Data held"}, int'(Data), int'(b));
  endtask

  initial begin
    string g0, g1;

`ifdef UART_TX_PARITY_EN
    vecs[0] = '{8'hA5, "01010010101"};
    vecs[1] = '{8'h07, "01110000011"};
    vecs[2] = '{8'h00, "00000000001"};
    vecs[3] = '{8'hFF, "01111111101"};
    vecs[4] = '{8'h3C, "00011110001"};
`else
    vecs[0] = '{8'hA5, "0101001011"};
    vecs[1] = '{8'h07, "0111000001"};
    vecs[2] = '{8'h00, "0000000001"};
    vecs[3] = '{8'hFF, "0111111111"};
    vecs[4] = '{8'h3C, "0001111001"};
`endif

    // Reset held with start asserted
    #2;
    start = 1'b1;
    Data_in = 8'h3C;
    clr = 1'b0;
    #1;
    chk("reset tx", int'(tx), 1);
    chk("reset Data", int'(Data), 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("reset busy", int'(busy), 0);
      chk("reset load", int'(load), 0);
      chk("reset done", int'(done), 0);
    end
    start = 1'b0;
    clr = 1'b1;

    for (int i = 0; i < 5; i++) begin
      send_and_check(vecs[i].data, vecs[i].bits, $sformatf("vec%0d", i), 1'b0);
    end

    send_and_check(8'hA5, vecs[0].bits, "poke", 1'b1);

    // Back-to-back with start held across the first frame
    @(negedge clk);
    start = 1'b1;
    Data_in = 8'h00;
    @(posedge clk);
    @(negedge clk);
    Data_in = 8'hFF;
    g0 = "";
    g1 = "";
    for (int c = 1; c <= 2 * FL + 2; c++) begin
      if (c == FL) chk("b2b done1", int'(done), 1);
      if (c == FL + 1) begin
        chk("b2b gap tx", int'(tx), 1);
        chk("b2b gap busy", int'(busy), 0);
      end
      if (c == FL + 2) begin
        chk("b2b start2 tx", int'(tx), 0);
        chk("b2b start2 load", int'(load), 1);
      end
      if (c <= FL && (c - 1) % N == N / 2) g0 = {g0, tx ? "1" : "0"};
      if (c >= FL + 2 && c <= 2 * FL + 1 && (c - FL - 2) % N == N / 2) g1 = {g1, tx ? "1" : "0"};
      if (c == 2 * FL + 1) chk("b2b done2", int'(done), 1);
      if (c == 2 * FL + 2) chk("b2b end busy", int'(busy), 0);
      if (c == FL + 3) start = 1'b0;
      @(negedge clk);
    end
    chk_s("b2b frame1", g0, model_bits(8'h00));
    chk_s("b2b frame2", g1, model_bits(8'hFF));

    // Reset in the middle of data bit 3
    @(negedge clk);
    start = 1'b1;
    Data_in = 8'h5A;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c < 4 * N + 2; c++) @(negedge clk);
    chk("midrst busy before", int'(busy), 1);
    clr = 1'b0;
    #1;
    chk("midrst tx", int'(tx), 1);
    chk("midrst busy", int'(busy), 0);
    chk("midrst Data", int'(Data), 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("midrst done", int'(done), 0);
    end
    clr = 1'b1;
    send_and_check(8'hA5, vecs[0].bits, "after midrst", 1'b0);

    // Randomized frames against the bit-level model
    for (int i = 0; i < 16; i++) begin
      logic [7:0] b;
      int gap;
      b = 8'($urandom);
      gap = $urandom_range(0, 3);
      for (int j = 0; j < gap; j++) @(negedge clk);
      send_and_check(b, model_bits(b), $sformatf("rand%0d_%02h", i, b), 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
